// File: rtl/pool_window_gen.sv
// Stride-2 2x2 window generator: buffers one row and emits four-lane windows for the pooling unit.
// Define POOL_WIN_PAD_EN to honour odd frame dimensions with zero-padded edge windows.
module pool_window_gen #(
  parameter int DATA_W    = 16,
  parameter int MAX_WIDTH = 64,
  parameter int DIM_W     = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIM_W-1:0]      cfg_width,
  input  logic [DIM_W-1:0]      cfg_height,
  input  logic [DATA_W-1:0]     pix_in,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic [4*DATA_W-1:0]   win_data,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int ADDR_W = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [DIM_W-1:0]  ONE  = DIM_W'(1);
  localparam logic [DIM_W-1:0]  TWO  = DIM_W'(2);
  localparam logic [DATA_W-1:0] ZERO = '0;

  typedef enum logic [2:0] {
    IDLE,
    ROW_TOP,
    ROW_BOT,
`ifdef POOL_WIN_PAD_EN
    PAD_BOT,
`endif
    FLUSH
  } state_t;

  state_t               state_q, state_d;
  logic [DIM_W-1:0]     col_q, col_d;
  logic [DIM_W-1:0]     row_q, row_d;
  logic [DIM_W-1:0]     effW_q, effW_d;
  logic [DIM_W-1:0]     effH_q, effH_d;
  logic [DATA_W-1:0]    hold_q, hold_d;
  logic [4*DATA_W-1:0]  winData_q, winData_d;
  logic                 winValid_q, winValid_d;
  logic                 done_q, done_d;

  logic [DATA_W-1:0]    lineBuf [MAX_WIDTH];
  logic                 lineWe;
  logic [ADDR_W-1:0]    loIdx, hiIdx;
  logic [DATA_W-1:0]    rdLo, rdHi;
  logic [DIM_W-1:0]     effWStart, effHStart;
  logic                 lastCol, outFree, winSlot, padLast;

  // Reads always address the column pair containing col_q
  assign loIdx   = col_q[ADDR_W-1:0] & ~ADDR_W'(1);
  assign hiIdx   = loIdx | ADDR_W'(1);
  assign rdLo    = lineBuf[loIdx];
  assign rdHi    = lineBuf[hiIdx];
  assign lastCol = (col_q == effW_q - ONE);
  assign outFree = !winValid_q || win_ready;
  assign winSlot = col_q[0] || lastCol;

`ifdef POOL_WIN_PAD_EN
  assign effWStart = cfg_width;
  assign effHStart = cfg_height;
  assign padLast   = lastCol && !col_q[0];
`else
  assign effWStart = cfg_width & ~ONE;
  assign effHStart = cfg_height & ~ONE;
  assign padLast   = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    effW_d     = effW_q;
    effH_d     = effH_q;
    hold_d     = hold_q;
    winData_d  = winData_q;
    winValid_d = winValid_q && !win_ready;
    done_d     = 1'b0;
    pix_ready  = 1'b0;
    lineWe     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          effW_d = effWStart;
          effH_d = effHStart;
          col_d  = '0;
          row_d  = '0;
          if (effWStart == '0 || effHStart == '0) done_d = 1'b1;
          else                                    state_d = ROW_TOP;
        end
      end
      ROW_TOP: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          lineWe = 1'b1;
          if (lastCol) begin
            col_d   = '0;
            state_d = ROW_BOT;
`ifdef POOL_WIN_PAD_EN
            if (row_q == effH_q - ONE) state_d = PAD_BOT;
`endif
          end else begin
            col_d = col_q + ONE;
          end
        end
      end
      ROW_BOT: begin
        // Window-completing columns stall until the output register can take a new window
        pix_ready = winSlot ? outFree : 1'b1;
        if (pix_valid && pix_ready) begin
          if (winSlot) begin
            winValid_d = 1'b1;
            winData_d  = padLast ? {ZERO, pix_in, ZERO, rdLo} : {pix_in, hold_q, rdHi, rdLo};
          end else begin
            hold_d = pix_in;
          end
          if (lastCol) begin
            col_d   = '0;
            row_d   = row_q + TWO;
            state_d = (row_q + TWO == effH_q) ? FLUSH : ROW_TOP;
          end else begin
            col_d = col_q + ONE;
          end
        end
      end
`ifdef POOL_WIN_PAD_EN
      PAD_BOT: begin
        if (outFree) begin
          winValid_d = 1'b1;
          winData_d  = {ZERO, ZERO, (col_q + ONE >= effW_q) ? ZERO : rdHi, rdLo};
          if (col_q + TWO >= effW_q) begin
            col_d   = '0;
            state_d = FLUSH;
          end else begin
            col_d = col_q + TWO;
          end
        end
      end
`endif
      FLUSH: begin
        if (outFree) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      effW_q     <= '0;
      effH_q     <= '0;
      hold_q     <= '0;
      winData_q  <= '0;
      winValid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      effW_q     <= effW_d;
      effH_q     <= effH_d;
      hold_q     <= hold_d;
      winData_q  <= winData_d;
      winValid_q <= winValid_d;
      done_q     <= done_d;
    end
  end

  // Line buffer contents survive reset; only the top row ever writes it
  always_ff @(posedge clk) begin
    if (lineWe) lineBuf[col_q[ADDR_W-1:0]] <= pix_in;
  end

  assign win_data  = winData_q;
  assign win_valid = winValid_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_pool_window_gen.sv
// Randomized self-checking bench for pool_window_gen against a frame-level window model.
module tb_pool_window_gen;

  localparam int DATA_W    = 16;
  localparam int MAX_WIDTH = 64;
  localparam int DIM_W     = 7;
`ifdef POOL_WIN_PAD_EN
  localparam bit PadEn = 1'b1;
`else
  localparam bit PadEn = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [DIM_W-1:0]    cfg_width = '0;
  logic [DIM_W-1:0]    cfg_height = '0;
  logic [DATA_W-1:0]   pix_in = '0;
  logic                pix_valid = 1'b0;
  logic                pix_ready;
  logic [4*DATA_W-1:0] win_data;
  logic                win_valid;
  logic                win_ready = 1'b0;
  logic                busy;
  logic                done;

  int errCount = 0;
  int checkCount = 0;

  logic [DATA_W-1:0]   pixMem [0:1023];
  bit                  isComp [0:1023];
  logic [4*DATA_W-1:0] expWin [$];

  always #5 clk = ~clk;

  pool_window_gen #(.DATA_W(DATA_W), .MAX_WIDTH(MAX_WIDTH), .DIM_W(DIM_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready), .win_data(win_data),
    .win_valid(win_valid), .win_ready(win_ready), .busy(busy), .done(done)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", tag, observed, expected);
    end
  endtask

  // Frame-level model: pixel (r,c) is stream element r*effW+c; missing positions read as zero
  function automatic logic [DATA_W-1:0] pixAt(input int r, input int c, input int effW, input int effH);
    if (r < effH && c < effW) return pixMem[r*effW + c];
    return '0;
  endfunction

  task automatic buildModel(input int effW, input int effH);
    expWin.delete();
    for (int i = 0; i < 1024; i++) isComp[i] = 1'b0;
    if (effW == 0 || effH == 0) return;
    for (int r = 0; r < effH; r += 2) begin
      for (int c = 0; c < effW; c += 2) begin
        expWin.push_back({pixAt(r+1, c+1, effW, effH), pixAt(r+1, c, effW, effH),
                          pixAt(r, c+1, effW, effH), pixAt(r, c, effW, effH)});
        if (r + 1 < effH) isComp[(r+1)*effW + ((c+1 < effW) ? c+1 : effW-1)] = 1'b1;
      end
    end
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input int w, input int h, input int validPct, input int readyPct,
                               input int stallCycles, input int pokeAt, input int stallPixIdx);
    int effW, effH, expPix, cyc, pixIdx, winIdx, lastAcc, stallLeft;
    bit doneSeen, busyLow, prevComp, stallChecked, nonZero;
    effW = PadEn ? w : (w & ~1);
    effH = PadEn ? h : (h & ~1);
    nonZero = (effW != 0 && effH != 0);
    expPix = nonZero ? effW * effH : 0;
    buildModel(effW, effH);
    @(negedge clk);
    start = 1'b1;
    cfg_width = DIM_W'(w);
    cfg_height = DIM_W'(h);
    pix_valid = 1'b0;
    win_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; pixIdx = 0; winIdx = 0; lastAcc = -1; stallLeft = stallCycles;
    doneSeen = 0; busyLow = 0; prevComp = 0; stallChecked = 0;
    while (cyc < 20000) begin
      if (prevComp) checkOutput("win_latency", win_valid, 1'b1);
      if (done) begin
        doneSeen = 1;
        break;
      end
      if (!busy) busyLow = 1;
      start = (cyc == pokeAt);
      if (cyc == pokeAt) begin
        cfg_width = DIM_W'(2);
        cfg_height = DIM_W'(2);
      end
      pix_valid = ($urandom_range(99) < validPct);
      pix_in = pixMem[(pixIdx < 1024) ? pixIdx : 0];
      win_ready = ($urandom_range(99) < readyPct);
      if (stallLeft > 0 && win_valid && winIdx == 0) begin
        win_ready = 1'b0;
        stallLeft--;
      end
      #1;
      if (stallPixIdx >= 0 && pixIdx == stallPixIdx && win_valid && !win_ready && !stallChecked) begin
        checkOutput("stall_ready", pix_ready, 1'b0);
        stallChecked = 1;
      end
      prevComp = 0;
      if (win_valid && win_ready) begin
        if (winIdx < expWin.size()) checkOutput($sformatf("win%0d", winIdx), win_data, expWin[winIdx]);
        else checkOutput("win_overrun", winIdx, expWin.size());
        winIdx++;
        lastAcc = cyc;
      end
      if (pix_valid && pix_ready) begin
        prevComp = (pixIdx < 1024) ? isComp[pixIdx] : 1'b0;
        pixIdx++;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    pix_valid = 1'b0;
    win_ready = 1'b0;
    checkOutput("done_seen", doneSeen, 1'b1);
    checkOutput("win_count", winIdx, expWin.size());
    checkOutput("pix_count", pixIdx, expPix);
    if (nonZero) begin
      checkOutput("done_after_accept", cyc, lastAcc + 1);
      checkOutput("busy_held", busyLow, 1'b0);
    end else begin
      checkOutput("done_latency", cyc, 0);
    end
    if (stallPixIdx >= 0) checkOutput("stall_seen", stallChecked, 1'b1);
    if (doneSeen) begin
      checkOutput("busy_after_done", busy, 1'b0);
      checkOutput("valid_after_done", win_valid, 1'b0);
    end else begin
      pulseReset();
    end
  endtask

  task automatic fillSeq(input int base, input int n);
    for (int i = 0; i < n; i++) pixMem[i] = DATA_W'(base + i);
  endtask

  task automatic fillRand();
    for (int i = 0; i < 1024; i++) pixMem[i] = DATA_W'($urandom);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pix_ready"}, pix_ready, 1'b0);
    checkOutput({tag, "_win_valid"}, win_valid, 1'b0);
    checkOutput({tag, "_win_data"}, win_data, 64'h0);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_done"}, done, 1'b0);
  endtask

  task automatic resetMidFrame();
    int n;
    fillSeq(1, 16);
    @(negedge clk);
    start = 1'b1;
    cfg_width = DIM_W'(4);
    cfg_height = DIM_W'(4);
    @(negedge clk);
    start = 1'b0;
    pix_valid = 1'b1;
    win_ready = 1'b0;
    n = 0;
    pix_in = pixMem[0];
    while (!win_valid && n < 50) begin
      #1;
      if (pix_ready) n++;
      @(negedge clk);
      pix_in = pixMem[n];
    end
    checkOutput("reset_setup_valid", win_valid, 1'b1);
    rst_n = 1'b0;
    pix_valid = 1'b0;
    #1;
    checkResetValues("midreset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkResetValues("reset");
    @(negedge clk);
    rst_n = 1'b1;

    fillSeq(1, 8);
    applyStimulus(4, 2, 100, 100, 0, -1, -1);

    fillSeq(1, 16);
    applyStimulus(4, 4, 100, 100, 5, -1, 7);

    fillRand();
    applyStimulus(64, 4, 70, 60, 0, 10, -1);

    fillSeq(0, 15);
    applyStimulus(5, 3, 80, 70, 0, -1, -1);

    resetMidFrame();
    fillSeq(7, 4);
    applyStimulus(2, 2, 100, 100, 0, -1, -1);

    applyStimulus(4, 0, 100, 100, 0, -1, -1);
    applyStimulus(4, 1, 100, 100, 0, -1, -1);

    for (int k = 0; k < 3; k++) begin
      fillRand();
      applyStimulus($urandom_range(64, 2), $urandom_range(9, 0), 75, 65, 0, 5, -1);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
